// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done bus between core control and the M-extension unit
//
// Purpose: bundles the request (start, flush, funct3, a, b) and the response
// (busy, done, result) of muldiv_unit.
// Ports (signals):
//   start   core -> unit  request, sampled only when busy=0
//   flush   core -> unit  abort the in-flight operation
//   funct3  core -> unit  operation select (MUL..REMU)
//   a, b    core -> unit  rs1 / rs2 operands
//   busy    unit -> core  operation in flight
//   done    unit -> core  one-cycle pulse, result valid
//   result  unit -> core  registered result, held until the next done
// Modports: master = core side, slave = unit side.

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, funct3, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RISC-V M-extension multiply/divide unit
//
// Purpose: MUL/MULH/MULHSU/MULHU by shift-add and DIV/DIVU/REM/REMU by
// restoring division, one bit per cycle on operand magnitudes, signs fixed up
// in a final cycle. Latency WIDTH+1 cycles; divide-by-zero and signed
// overflow finish in 1 cycle.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of muldiv_unit_if (start/flush/funct3/a/b in,
//          busy/done/result out)

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;       // product / quotient must be negated
  logic               rem_neg_q, rem_neg_d;
  logic               special_q, special_d; // acc_q[WIDTH-1:0] already holds the answer
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode, evaluated on the request inputs.
  logic             is_div, a_signed, b_signed, sa, sb, div_by_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div   = bus.funct3[2];
  assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
  assign sa       = a_signed && bus.a[WIDTH-1];
  assign sb       = b_signed && bus.b[WIDTH-1];
  assign a_mag    = sa ? -bus.a : bus.a;
  assign b_mag    = sb ? -bus.b : bus.b;
  assign div_by_zero = is_div && (bus.b == {WIDTH{1'b0}});
  assign div_ovf     = is_div && !bus.funct3[0] && (bus.a == MIN_NEG) &&
                       (bus.b == {WIDTH{1'b1}});

  // Shift-add step: conditionally add multiplicand into the high half (with
  // carry), then shift the whole accumulator right; the multiplier drains
  // out of the low half as the product fills in.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: the partial remainder shifted left needs WIDTH+1 bits
  // because it can reach 2*divisor-1 before the subtract.
  logic [WIDTH:0]     div_top, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_top - {1'b0, opnd_q};
  assign div_ge   = (div_top >= {1'b0, opnd_q});
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  // Sign fix-up and result select for the FIN cycle.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin_res;
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (special_q) begin
      fin_res = acc_q[WIDTH-1:0];
    end else begin
      case (op_q)
        3'b000:                 fin_res = prod[WIDTH-1:0];
        3'b001, 3'b010, 3'b011: fin_res = prod[2*WIDTH-1:WIDTH];
        3'b100, 3'b101:         fin_res = quo;
        default:                fin_res = rem;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    special_d = special_q;
    done_d    = 1'b0;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d      = bus.funct3;
          neg_d     = sa ^ sb;
          rem_neg_d = sa;
          opnd_d    = is_div ? b_mag : a_mag;
          if (div_by_zero) begin
            special_d = 1'b1;
            acc_d     = {{WIDTH{1'b0}}, (bus.funct3[1] ? bus.a : {WIDTH{1'b1}})};
            state_d   = S_FIN;
          end else if (div_ovf) begin
            special_d = 1'b1;
            acc_d     = {{WIDTH{1'b0}}, (bus.funct3[1] ? {WIDTH{1'b0}} : bus.a)};
            state_d   = S_FIN;
          end else begin
            special_d = 1'b0;
            acc_d     = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d   = 1'b1;
          result_d = fin_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'b000;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      special_q <= special_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (WIDTH=32)

module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model, written from the ISA definition in 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, ps;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'b001: begin pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; ps = pa * pb; return ps[63:32]; end
      3'b010: begin pa = {{32{a[31]}}, a}; pb = {32'b0, b}; ps = pa * pb; return ps[63:32]; end
      3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LAT;
  endfunction

  // Scoreboard monitor: every done must match the oldest pending request.
  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_res"}, bus.result, e.res);
        check({e.tag, "_lat"}, 32'(cyc), 32'(e.cyc));
        last_res = e.res;
      end
    end
  end

  // Called just after a negedge with busy=0: drives one request, pushes its expectation.
  task automatic drive_now(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    e.tag = tag;
    e.res = exp;
    e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.a      = a;
    bus.b      = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic launch(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge clk);
    drive_now(tag, f, a, b, exp, lat);
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    launch(tag, f, a, b, exp, lat);
    drain(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_result", bus.result, 32'h0);
    end

    // Directed multiply / divide / special cases.
    run_op("mul",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    run_op("mulh",      3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT);
    run_op("mulhu",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT);
    run_op("div",       3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT);
    run_op("rem",       3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT);
    run_op("divu",      3'b101, 32'd100,        32'd7,         32'd14,        LAT);
    run_op("remu",      3'b111, 32'd100,        32'd7,         32'd2,         LAT);
    run_op("div_ovf",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
    run_op("div_zero",  3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_zero", 3'b111, 32'd5,          32'd0,         32'd5,         1);

    // Flush mid-CALC: no done, busy drops, result holds the last value.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_busy_before", 32'(bus.busy), 32'h1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'h0);
    check("flush_done", 32'(bus.done), 32'h0);
    check("flush_result", bus.result, last_res);
    repeat (40) @(negedge clk);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, LAT);

    // Start pulses and operand changes while busy are ignored.
    launch("busy_ignore", 3'b101, 32'd1000, 32'd3, 32'd333, LAT);
    for (int i = 0; i < 6; i++) begin
      bus.start  = 1'b1;
      bus.funct3 = 3'($urandom_range(0, 7));
      bus.a      = $urandom;
      bus.b      = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain("busy_ignore");

    // Back-to-back: new start in the done cycle.
    launch("b2b_first", 3'b000, 32'd1234, 32'd5678, 32'd7006652, LAT);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.done) break;
      end
      if (i == 100) check("b2b_wait_done", 32'(bus.done), 32'h1);
    end
    drive_now("b2b_second", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT);
    drain("b2b");

    // Reset mid-CALC discards the operation and clears result.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b011; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    check("rst_mid_result", bus.result, 32'h0);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = b & 32'hFF;
      if (i % 7 == 3) b = 32'h0;
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, model(f, a, b), model_lat(f, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
